// File: rtl/ex_mem_skid_stage_if.sv
// EX->MEM stage bus: execute-side handshake and payload, memory-side handshake and
// payload, and the squash strobe.
//   master : environment view (drives E-side payload, InValid, OutReady, Flush)
//   slave  : pipeline stage view (drives InReady, OutValid, M-side payload)
// Optional macro EXMEM_STALL_CNT_EN adds the StallCnt back-pressure counter output.
// Parameters must match those of the ex_mem_skid_stage instance attached to it.
interface ex_mem_skid_stage_if #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned RESULT_SRC_WIDTH = 2
`ifdef EXMEM_STALL_CNT_EN
  , parameter int unsigned CNT_WIDTH      = 16
`endif
);
  logic                        Flush;
  logic                        InValid;
  logic                        InReady;
  logic                        RegWriteE;
  logic [RESULT_SRC_WIDTH-1:0] ResultSrcE;
  logic                        MemWriteE;
  logic                        StSrcE;
  logic                        LdSrcE;
  logic [DATA_WIDTH-1:0]       ALUResultE;
  logic [DATA_WIDTH-1:0]       WriteDataE;
  logic [REG_ADDR_WIDTH-1:0]   RdE;
  logic [DATA_WIDTH-1:0]       PC_PlusE;

  logic                        OutValid;
  logic                        OutReady;
  logic                        RegWriteM;
  logic [RESULT_SRC_WIDTH-1:0] ResultSrcM;
  logic                        MemWriteM;
  logic                        StSrcM;
  logic                        LdSrcM;
  logic [DATA_WIDTH-1:0]       ALUResultM;
  logic [DATA_WIDTH-1:0]       WriteDataM;
  logic [REG_ADDR_WIDTH-1:0]   RdM;
  logic [DATA_WIDTH-1:0]       PC_PlusM;

`ifdef EXMEM_STALL_CNT_EN
  logic [CNT_WIDTH-1:0]        StallCnt;
`endif

  modport master (
`ifdef EXMEM_STALL_CNT_EN
    input  StallCnt,
`endif
    output Flush, InValid, RegWriteE, ResultSrcE, MemWriteE, StSrcE, LdSrcE,
    output ALUResultE, WriteDataE, RdE, PC_PlusE, OutReady,
    input  InReady, OutValid, RegWriteM, ResultSrcM, MemWriteM, StSrcM, LdSrcM,
    input  ALUResultM, WriteDataM, RdM, PC_PlusM
  );

  modport slave (
`ifdef EXMEM_STALL_CNT_EN
    output StallCnt,
`endif
    input  Flush, InValid, RegWriteE, ResultSrcE, MemWriteE, StSrcE, LdSrcE,
    input  ALUResultE, WriteDataE, RdE, PC_PlusE, OutReady,
    output InReady, OutValid, RegWriteM, ResultSrcM, MemWriteM, StSrcM, LdSrcM,
    output ALUResultM, WriteDataM, RdM, PC_PlusM
  );
endinterface

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// InReady comes straight from a flop, so no combinational path runs from OutReady back
// to the execute stage. Flush squashes every held and incoming entry.
// Ports:
//   clk   : clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ex_mem_skid_stage_if.slave (E-side inputs, M-side outputs, Flush)
// Optional macro EXMEM_STALL_CNT_EN adds the saturating StallCnt counter (CNT_WIDTH bits).
module ex_mem_skid_stage #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned RESULT_SRC_WIDTH = 2
`ifdef EXMEM_STALL_CNT_EN
  , parameter int unsigned CNT_WIDTH      = 16
`endif
) (
  input logic               clk,
  input logic               rst_n,
  ex_mem_skid_stage_if.slave bus
);

  // Payload word: RegWrite, ResultSrc, MemWrite, StSrc, LdSrc, ALUResult, WriteData, Rd, PC_Plus
  localparam int unsigned PW = 4 + RESULT_SRC_WIDTH + 3 * DATA_WIDTH + REG_ADDR_WIDTH;

  // EMPTY: nothing held; ONE: main only; FULL: main and skid
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] in_pl;
  logic [PW-1:0] main_pl_q, main_pl_d;
  logic [PW-1:0] skid_pl_q, skid_pl_d;
  logic          in_ready;
  logic          main_valid;
  logic          accept;
  logic          drain;
  logic          m_regwrite;
  logic          m_memwrite;

  assign in_pl = {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.StSrcE, bus.LdSrcE,
                  bus.ALUResultE, bus.WriteDataE, bus.RdE, bus.PC_PlusE};

  assign in_ready   = (state_q != StFull);
  assign main_valid = (state_q != StEmpty);
  assign accept     = bus.InValid && in_ready;
  assign drain      = main_valid && bus.OutReady;

  always_comb begin
    state_d   = state_q;
    main_pl_d = main_pl_q;
    skid_pl_d = skid_pl_q;
    if (bus.Flush) begin
      // Payload registers are left alone so M-side fields hold through the bubble.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d   = StOne;
            main_pl_d = in_pl;
          end
        end
        StOne: begin
          if (accept && drain) begin
            main_pl_d = in_pl;
          end else if (accept) begin
            state_d   = StFull;
            skid_pl_d = in_pl;
          end else if (drain) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (drain) begin
            state_d   = StOne;
            main_pl_d = skid_pl_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      main_pl_q <= '0;
      skid_pl_q <= '0;
    end else begin
      state_q   <= state_d;
      main_pl_q <= main_pl_d;
      skid_pl_q <= skid_pl_d;
    end
  end

  assign {m_regwrite, bus.ResultSrcM, m_memwrite, bus.StSrcM, bus.LdSrcM,
          bus.ALUResultM, bus.WriteDataM, bus.RdM, bus.PC_PlusM} = main_pl_q;

  // Write enables are gated so a bubble can never commit a stale instruction.
  assign bus.RegWriteM = main_valid && m_regwrite;
  assign bus.MemWriteM = main_valid && m_memwrite;
  assign bus.OutValid  = main_valid;
  assign bus.InReady   = in_ready;

`ifdef EXMEM_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  // Counts back-pressure cycles, saturating; Flush deliberately does not clear it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (main_valid && !bus.OutReady && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign bus.StallCnt = stall_cnt_q;
`endif

endmodule
